alu_share_arbiter: RTL

- Shares one combinational 64-bit ALU (BusA/BusB/ALUCtrl -> BusW/Zero) between two requesters, e.g. the execute-stage sequencer and an address/branch-compare unit.
- Accepts one operation at a time through a valid/ready request port per requester, with round-robin arbitration.
- Drives the ALU from registered operands and captures BusW/Zero.
- Returns the result on a valid/ready response port to the requester that issued the operation.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 22 ++
 rtl/alu_share_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: bus widths, opcodes, FSM states.
package alu_pkg;

    localparam int unsigned ALU_W      = 64;
    localparam int unsigned ALU_CTRL_W = 4;

    // Opcodes understood by the shared ALU; the arbiter passes them through untouched.
    localparam logic [ALU_CTRL_W-1:0] ALU_AND     = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR      = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD     = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB     = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB_ALT = 4'b0011;
    localparam logic [ALU_CTRL_W-1:0] ALU_PASSB   = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; combinational one-hot grant.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       enable,
    output logic [1:0] grant
);

    // Sole requester wins; on contention the one not served last wins.
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            unique case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between two valid/ready requesters.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = ALU_W,
    parameter int unsigned CTRL_W = ALU_CTRL_W
) (
    input  logic              CLK,
    input  logic              ResetL,
    input  logic              Req0Valid,
    output logic              Req0Ready,
    input  logic [WIDTH-1:0]  Req0A,
    input  logic [WIDTH-1:0]  Req0B,
    input  logic [CTRL_W-1:0] Req0Ctrl,
    input  logic              Req1Valid,
    output logic              Req1Ready,
    input  logic [WIDTH-1:0]  Req1A,
    input  logic [WIDTH-1:0]  Req1B,
    input  logic [CTRL_W-1:0] Req1Ctrl,
    output logic              Resp0Valid,
    input  logic              Resp0Ready,
    output logic              Resp1Valid,
    input  logic              Resp1Ready,
    output logic [WIDTH-1:0]  RespData,
    output logic              RespZero,
    output logic [WIDTH-1:0]  AluBusA,
    output logic [WIDTH-1:0]  AluBusB,
    output logic [CTRL_W-1:0] AluCtrl,
    input  logic [WIDTH-1:0]  AluBusW,
    input  logic              AluZero
);

    state_t     state;
    state_t     state_nxt;
    logic       owner;
    logic       last_grant;
    logic [1:0] grant;
    logic       arb_en;
    logic       accept;
    logic       resp_hs;

    // Arbitrate only while idle and out of reset so Ready stays low during reset.
    assign arb_en = (state == IDLE) && ResetL;

    rr_arb2 u_rr_arb2 (
        .req    ({Req1Valid, Req0Valid}),
        .last   (last_grant),
        .enable (arb_en),
        .grant  (grant)
    );

    assign Req0Ready  = grant[0];
    assign Req1Ready  = grant[1];
    assign accept     = |grant;
    assign Resp0Valid = (state == RESP) && !owner;
    assign Resp1Valid = (state == RESP) && owner;
    assign resp_hs    = (state == RESP) && (owner ? Resp1Ready : Resp0Ready);

    // State register.
    always_ff @(posedge CLK or negedge ResetL) begin
        if (!ResetL) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept -> one ALU cycle -> hold result until the owner takes it.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)  state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (resp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture on accept, result capture at the end of the ALU cycle.
    always_ff @(posedge CLK or negedge ResetL) begin
        if (!ResetL) begin
            AluBusA    <= '0;
            AluBusB    <= '0;
            AluCtrl    <= '0;
            RespData   <= '0;
            RespZero   <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (accept) begin
                AluBusA    <= grant[1] ? Req1A    : Req0A;
                AluBusB    <= grant[1] ? Req1B    : Req0B;
                AluCtrl    <= grant[1] ? Req1Ctrl : Req0Ctrl;
                owner      <= grant[1];
                last_grant <= grant[1];
            end
            if (state == EXEC) begin
                RespData <= AluBusW;
                RespZero <= AluZero;
            end
        end
    end

endmodule
